// File: rtl/sum_display_if.sv
// Accumulator-to-display link: result strobe and data in, segment drive and
// status out.
interface sum_display_if;
   logic       done;
   logic [7:0] sum;
   logic [6:0] hex2;
   logic [6:0] hex1;
   logic [6:0] hex0;
   logic       busy;
   logic       overrun;
   logic [7:0] result_cnt;

   // Accumulator side: produces results, observes display status.
   modport master (
      output done, sum,
      input  hex2, hex1, hex0, busy, overrun, result_cnt
   );

   // Display stage side.
   modport slave (
      input  done, sum,
      output hex2, hex1, hex0, busy, overrun, result_cnt
   );
endinterface

// File: rtl/sum_display.sv
// Display stage for the 8-bit accumulator: captures sum on done, converts it to
// three BCD digits with a bit-serial double-dabble and drives three active-low
// seven-segment displays. A one-entry pending slot absorbs a result arriving
// mid-conversion; further results are dropped and flagged in overrun.
module sum_display #(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic         ck,
   input  logic         reset_l,
   sum_display_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_ZERO   = 7'h40;
   localparam logic [6:0] HEX_HI_RST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

   state_t      state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  iter_q, iter_d;
   logic        pend_val_q, pend_val_d;
   logic [7:0]  pend_data_q, pend_data_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [6:0]  hex2_q, hex2_d;
   logic [6:0]  hex1_q, hex1_d;
   logic [6:0]  hex0_q, hex0_d;

   logic [11:0] bcd_adj;
   logic [6:0]  seg2, seg1, seg0;

   // Double-dabble correction applied to one BCD nibble before the shift.
   function automatic logic [3:0] dabble(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Per-nibble add-3 correction of the current BCD value.
   always_comb begin
      bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
   end

   // Segment patterns for the finished BCD value, with leading-zero blanking.
   always_comb begin
      seg2 = seg7(bcd_q[11:8]);
      seg1 = seg7(bcd_q[7:4]);
      seg0 = seg7(bcd_q[3:0]);
      if (BLANK_LEADING) begin
         if (bcd_q[11:8] == 4'd0) seg2 = SEG_BLANK;
         if (bcd_q[11:4] == 8'd0) seg1 = SEG_BLANK;
      end
   end

   // Next-state logic: conversion sequencing, pending slot and display update.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      iter_d      = iter_q;
      pend_val_d  = pend_val_q;
      pend_data_d = pend_data_q;
      overrun_d   = overrun_q;
      cnt_d       = cnt_q;
      hex2_d      = hex2_q;
      hex1_d      = hex1_q;
      hex0_d      = hex0_q;

      case (state_q)
         IDLE: begin
            if (bus.done) begin
               bin_d   = bus.sum;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = CONV;
            end
         end

         CONV: begin
            {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
            iter_d         = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = UPDATE;
            if (bus.done) begin
               if (!pend_val_q) begin
                  pend_data_d = bus.sum;
                  pend_val_d  = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end

         UPDATE: begin
            hex2_d = seg2;
            hex1_d = seg1;
            hex0_d = seg0;
            cnt_d  = cnt_q + 8'd1;
            if (pend_val_q) begin
               // Queued result starts now; a simultaneous done refills the slot.
               bin_d   = pend_data_q;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = CONV;
               if (bus.done) begin
                  pend_data_d = bus.sum;
               end else begin
                  pend_val_d = 1'b0;
               end
            end else if (bus.done) begin
               bin_d   = bus.sum;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge ck or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         iter_q      <= '0;
         pend_val_q  <= 1'b0;
         pend_data_q <= '0;
         overrun_q   <= 1'b0;
         cnt_q       <= '0;
         hex2_q      <= HEX_HI_RST;
         hex1_q      <= HEX_HI_RST;
         hex0_q      <= SEG_ZERO;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         iter_q      <= iter_d;
         pend_val_q  <= pend_val_d;
         pend_data_q <= pend_data_d;
         overrun_q   <= overrun_d;
         cnt_q       <= cnt_d;
         hex2_q      <= hex2_d;
         hex1_q      <= hex1_d;
         hex0_q      <= hex0_d;
      end
   end

   assign bus.hex2       = hex2_q;
   assign bus.hex1       = hex1_q;
   assign bus.hex0       = hex0_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.overrun    = overrun_q;
   assign bus.result_cnt = cnt_q;

endmodule
